// File: rtl/encoder_pkg.sv
// encoder_pkg: shared constants, FSM state type and one-hot to binary helper for encoder_8_3_arb
package encoder_pkg;
  localparam int ENC_WIDTH = 8;
  localparam int ENC_IDX_W = 3;
  typedef enum logic {ENC_IDLE, ENC_PRESENT} enc_state_t;
  function automatic logic [ENC_IDX_W-1:0] onehot_to_bin(input logic [ENC_WIDTH-1:0] oh);
    logic [ENC_IDX_W-1:0] b;
    b = '0;
    for (int i = 0; i < ENC_WIDTH; i++) if (oh[i]) b = b | ENC_IDX_W'(i);
    return b;
  endfunction
endpackage

// File: rtl/priority_encoder_8_3.sv
// priority_encoder_8_3: lowest-set-bit search over vec, starting at start and wrapping
module priority_encoder_8_3
  import encoder_pkg::*;
(
  input  logic [ENC_WIDTH-1:0] vec,
  input  logic [ENC_IDX_W-1:0] start,
  output logic [ENC_IDX_W-1:0] index,
  output logic                 found
);
  logic [2*ENC_WIDTH-1:0] dbl;
  logic [ENC_WIDTH-1:0]   rot;
  logic [ENC_WIDTH-1:0]   low;
  // rotating right by start makes the search origin bit 0; the offset is added back afterwards
  always_comb begin
    dbl   = {vec, vec} >> start;
    rot   = dbl[ENC_WIDTH-1:0];
    low   = rot & (~rot + ENC_WIDTH'(1));
    found = |vec;
    index = onehot_to_bin(low) + start;
  end
endmodule

// File: rtl/encoder_8_3_arb.sv
// encoder_8_3_arb: pending-request collector presenting one index at a time with valid/ack (ENCODER_ROUND_ROBIN_EN selects rotating priority)
module encoder_8_3_arb
  import encoder_pkg::*;
#(
  parameter int WIDTH = ENC_WIDTH,
  parameter int IDX_W = ENC_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             ack,
  output logic [IDX_W-1:0] idx,
  output logic             valid,
  output logic [IDX_W:0]   pend_cnt
);
  enc_state_t       state;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] pend_nxt;
  logic [IDX_W-1:0] enc_idx;
  logic [IDX_W-1:0] start;
  logic             found;
  always_comb begin
    clr      = (valid && ack) ? WIDTH'(1) << idx : '0;
    pend_nxt = (pending & ~clr) | req;
  end
`ifdef ENCODER_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;
  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= '0;
    else if (state == ENC_PRESENT && ack) rr_ptr <= idx + IDX_W'(1);
  end
  assign start = rr_ptr;
`else
  assign start = '0;
`endif
  priority_encoder_8_3 u_prio (
    .vec  (pending),
    .start(start),
    .index(enc_idx),
    .found(found)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      state    <= ENC_IDLE;
      idx      <= '0;
      valid    <= 1'b0;
      pend_cnt <= '0;
    end else begin
      pending  <= pend_nxt;
      pend_cnt <= (IDX_W+1)'($countones(pend_nxt));
      if (state == ENC_IDLE && found) begin
        idx   <= enc_idx;
        valid <= 1'b1;
        state <= ENC_PRESENT;
      end else if (state == ENC_PRESENT && ack) begin
        valid <= 1'b0;
        state <= ENC_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_encoder_8_3_arb.sv
// tb_encoder_8_3_arb: table-driven vectors plus hand sequences for hold-off, mid-grant reset and full-load arbitration
module tb_encoder_8_3_arb;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic       ack = 1'b0;
  logic [2:0] idx;
  logic       valid;
  logic [3:0] pend_cnt;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       ack;
    logic       v;
    logic [2:0] i;
    logic [3:0] c;
  } vec_t;
  vec_t tbl[17];
  encoder_8_3_arb dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ack     (ack),
    .idx     (idx),
    .valid   (valid),
    .pend_cnt(pend_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic chk_all(input string nm, input logic v, input logic [2:0] i, input logic [3:0] c);
    chk({nm, ".valid"}, 32'(valid), 32'(v));
    chk({nm, ".idx"}, 32'(idx), 32'(i));
    chk({nm, ".cnt"}, 32'(pend_cnt), 32'(c));
  endtask
  initial begin
    int k;
    logic [2:0] exp_idx;
    tbl[0]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 4'd0};
    tbl[1]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 3'd0, 4'd0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 4'd0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 4'd0};
    tbl[4]  = '{1'b0, 8'h24, 1'b0, 1'b0, 3'd0, 4'd2};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 4'd2};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 4'd1};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd5, 4'd1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd5, 4'd0};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd5, 4'd0};
    tbl[10] = '{1'b0, 8'h10, 1'b0, 1'b0, 3'd5, 4'd1};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd4, 4'd1};
    tbl[12] = '{1'b0, 8'h10, 1'b1, 1'b0, 3'd4, 4'd1};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd4, 4'd1};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd4, 4'd0};
    tbl[15] = '{1'b0, 8'h08, 1'b0, 1'b0, 3'd4, 4'd1};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd3, 4'd1};
    for (int n = 0; n < 17; n++) begin
      rst = tbl[n].rst;
      req = tbl[n].req;
      ack = tbl[n].ack;
      tick();
      chk_all($sformatf("vec%0d", n), tbl[n].v, tbl[n].i, tbl[n].c);
    end
    ack = 1'b0;
    for (int n = 0; n < 10; n++) begin
      req = (n == 0 || n == 5) ? 8'h80 : 8'h00;
      tick();
      chk_all($sformatf("hold%0d", n), 1'b1, 3'd3, 4'd2);
    end
    req = '0;
    ack = 1'b1;
    tick();
    chk_all("hold_ack3", 1'b0, 3'd3, 4'd1);
    ack = 1'b0;
    tick();
    chk_all("hold_next", 1'b1, 3'd7, 4'd1);
    ack = 1'b1;
    tick();
    chk_all("hold_ack7", 1'b0, 3'd7, 4'd0);
    ack = 1'b0;
    req = 8'hFF;
    tick();
    req = '0;
    tick();
    chk_all("pre_rst", 1'b1, 3'd0, 4'd8);
    rst = 1'b1;
    tick();
    chk_all("mid_rst", 1'b0, 3'd0, 4'd0);
    rst = 1'b0;
    tick();
    chk_all("post_rst", 1'b0, 3'd0, 4'd0);
    req = 8'hFF;
    for (int g = 0; g < 10; g++) begin
      k = 0;
      while (valid !== 1'b1 && k < 4) begin
        tick();
        k++;
      end
`ifdef ENCODER_ROUND_ROBIN_EN
      exp_idx = 3'(g);
`else
      exp_idx = 3'd0;
`endif
      chk_all($sformatf("full%0d", g), 1'b1, exp_idx, 4'd8);
      ack = 1'b1;
      tick();
      ack = 1'b0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
